// File: rtl/dmem_bridge_if.sv
// Core-side data port of the data-memory bridge.
// The core (master) issues word reads and byte-lane writes; the bridge
// (slave) returns read data, a stall handshake and a protocol-error pulse.
interface dmem_bridge_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] Address;
   logic              ReadEn;
   logic              WriteEn;
   logic              WriteL;
   logic              WriteR;
   logic [31:0]       WriteData;
   logic [31:0]       ReadData;
   logic              nStall;
   logic              ProtErr;

   modport master (
      output Address, ReadEn, WriteEn, WriteL, WriteR, WriteData,
      input  ReadData, nStall, ProtErr
   );

   modport slave (
      input  Address, ReadEn, WriteEn, WriteL, WriteR, WriteData,
      output ReadData, nStall, ProtErr
   );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory responder: turns 32-bit big-endian core accesses into two
// halfword accesses on a 16-bit synchronous SRAM, builds SWL/SWR byte lanes
// and holds the core with nStall until the access has finished.
module dmem_bridge #(
   parameter int ADDR_W = 16
) (
   input  logic              Clock,
   input  logic              nReset,
   dmem_bridge_if.slave      bus,
   output logic [ADDR_W-2:0] o_SramAddr,
   output logic              o_SramEn,
   output logic              o_SramWe,
   output logic [1:0]        o_SramBe,
   output logic [15:0]       o_SramWData,
   input  logic [15:0]       i_SramRData
);

   typedef enum logic [2:0] {
      IDLE,
      RD_HI,
      RD_LO,
      RD_WAIT,
      WR_HI,
      WR_LO,
      DONE
   } state_t;

   state_t            r_State;
   logic [ADDR_W-3:0] r_WordAddr;
   logic [1:0]        r_LoBe;
   logic [15:0]       r_LoData;
   logic [31:0]       r_ReadData;
   logic              r_ProtErr;
   logic [ADDR_W-2:0] r_SramAddr;
   logic              r_SramEn;
   logic              r_SramWe;
   logic [1:0]        r_SramBe;
   logic [15:0]       r_SramWData;

   logic [1:0]        w_Offset;
   logic [1:0]        w_ShiftR;
   logic              w_ModeL;
   logic              w_ModeR;
   logic [ADDR_W-3:0] w_WordAddr;
   logic [3:0]        w_ByteEn;
   logic [31:0]       w_LaneData;
   logic [31:0]       w_MaskedData;
   logic              w_ProtErr;
   logic              w_nStall;

   assign w_Offset   = bus.Address[1:0];
   assign w_ShiftR   = 2'd3 - w_Offset;
   assign w_WordAddr = bus.Address[ADDR_W-1:2];
   assign w_ModeL    = bus.WriteL & ~bus.WriteR;
   assign w_ModeR    = bus.WriteR & ~bus.WriteL;

   // Illegal request combinations; both qualifiers together or a misaligned
   // plain store degrade to an aligned full-word write, stray qualifiers
   // without WriteEn are dropped.
   assign w_ProtErr = (bus.ReadEn & bus.WriteEn)
                    | (bus.WriteEn & ~bus.WriteL & ~bus.WriteR & (w_Offset != 2'd0))
                    | (bus.WriteEn & bus.WriteL & bus.WriteR)
                    | (~bus.WriteEn & (bus.WriteL | bus.WriteR));

   // Byte-lane steering: bit 3 of w_ByteEn / bits [31:24] of the lane word
   // are memory byte 0 of the aligned word. SWL shifts the store right by
   // the offset, SWR shifts it left so its last byte lands on the offset.
   always_comb begin
      w_ByteEn     = 4'b1111;
      w_LaneData   = bus.WriteData;
      w_MaskedData = 32'd0;
      if (w_ModeL) begin
         w_ByteEn   = 4'b1111 >> w_Offset;
         w_LaneData = bus.WriteData >> {w_Offset, 3'b000};
      end else if (w_ModeR) begin
         w_ByteEn   = 4'b1111 << w_ShiftR;
         w_LaneData = bus.WriteData << {w_ShiftR, 3'b000};
      end
      for (int i = 0; i < 4; i++) begin
         w_MaskedData[8*i +: 8] = w_ByteEn[i] ? w_LaneData[8*i +: 8] : 8'd0;
      end
   end

   // Core hold: stalled through every access state and already in the
   // request cycle itself; reset always releases the core.
   always_comb begin
      w_nStall = 1'b1;
      if (nReset) begin
         w_nStall = 1'b1;
      end else begin
         case (r_State)
            RD_HI, RD_LO, RD_WAIT, WR_HI, WR_LO: w_nStall = 1'b0;
            IDLE:    w_nStall = ~(bus.ReadEn | bus.WriteEn);
            default: w_nStall = 1'b1;
         endcase
      end
   end

   // Access sequencer: issues the high then low halfword strobe, assembles
   // read data one cycle behind each read strobe, and pulses ProtErr.
   always_ff @(posedge Clock) begin
      if (nReset) begin
         r_State     <= IDLE;
         r_WordAddr  <= '0;
         r_LoBe      <= 2'b00;
         r_LoData    <= 16'd0;
         r_ReadData  <= 32'd0;
         r_ProtErr   <= 1'b0;
         r_SramAddr  <= '0;
         r_SramEn    <= 1'b0;
         r_SramWe    <= 1'b0;
         r_SramBe    <= 2'b00;
         r_SramWData <= 16'd0;
      end else begin
         r_ProtErr <= 1'b0;
         case (r_State)
            IDLE: begin
               r_ProtErr  <= w_ProtErr;
               r_WordAddr <= w_WordAddr;
               if (bus.WriteEn) begin
                  r_State     <= WR_HI;
                  r_SramEn    <= 1'b1;
                  r_SramWe    <= 1'b1;
                  r_SramAddr  <= {w_WordAddr, 1'b0};
                  r_SramBe    <= w_ByteEn[3:2];
                  r_SramWData <= w_MaskedData[31:16];
                  r_LoBe      <= w_ByteEn[1:0];
                  r_LoData    <= w_MaskedData[15:0];
               end else if (bus.ReadEn) begin
                  r_State     <= RD_HI;
                  r_SramEn    <= 1'b1;
                  r_SramWe    <= 1'b0;
                  r_SramAddr  <= {w_WordAddr, 1'b0};
                  r_SramBe    <= 2'b11;
                  r_SramWData <= 16'd0;
               end
            end
            RD_HI: begin
               r_State    <= RD_LO;
               r_SramAddr <= {r_WordAddr, 1'b1};
            end
            RD_LO: begin
               r_State            <= RD_WAIT;
               r_ReadData[31:16]  <= i_SramRData;
               r_SramEn           <= 1'b0;
               r_SramBe           <= 2'b00;
            end
            RD_WAIT: begin
               r_State           <= DONE;
               r_ReadData[15:0]  <= i_SramRData;
            end
            WR_HI: begin
               r_State     <= WR_LO;
               r_SramAddr  <= {r_WordAddr, 1'b1};
               r_SramBe    <= r_LoBe;
               r_SramWData <= r_LoData;
            end
            WR_LO: begin
               r_State     <= DONE;
               r_SramEn    <= 1'b0;
               r_SramWe    <= 1'b0;
               r_SramBe    <= 2'b00;
               r_SramWData <= 16'd0;
            end
            DONE: begin
               r_State <= IDLE;
            end
            default: begin
               r_State <= IDLE;
            end
         endcase
      end
   end

   assign bus.ReadData = r_ReadData;
   assign bus.nStall   = w_nStall;
   assign bus.ProtErr  = r_ProtErr;
   assign o_SramAddr   = r_SramAddr;
   assign o_SramEn     = r_SramEn;
   assign o_SramWe     = r_SramWe;
   assign o_SramBe     = r_SramBe;
   assign o_SramWData  = r_SramWData;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
Data-memory responder for PROCESSOR. It sits between the core's data port (MemAddr/MemRead/MemWrite/WriteL/WriteR/WriteData/MemData/nStall) and a 16-bit-wide synchronous SRAM.
- Splits each 32-bit big-endian access into two halfword SRAM accesses.
- Generates SWL/SWR byte lanes.
- Holds the core with nStall until read data is valid or the write has been issued.
- Replaces the behavioural memory model in synthesised top-level builds.

Parameters:
ADDR_W, 16, processor byte-address width; SRAM halfword address is ADDR_W-1 bits.

Ports:
Clock      in   1       clock, rising edge
nReset     in   1       reset, synchronous, active-high
Address    in   ADDR_W  byte address from core
ReadEn     in   1       word read request
WriteEn    in   1       write request
WriteL     in   1       SWL qualifier (valid with WriteEn)
WriteR     in   1       SWR qualifier (valid with WriteEn)
WriteData  in   32      store data, byte0 = [31:24]
ReadData   out  32      read data, valid in DONE and held until the next read completes
nStall     out  1       0 = core must hold; 1 = core may advance
ProtErr    out  1       one-cycle pulse on illegal request
SramAddr   out  ADDR_W-1  halfword address
SramEn     out  1       SRAM access strobe
SramWe     out  1       1 = write, 0 = read
SramBe     out  2       byte enables; [1] = bits [15:8], [0] = bits [7:0]
SramWData  out  16      SRAM write data; disabled lanes driven 0
SramRData  in   16      SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (nReset=1 at a rising edge): state=IDLE; ReadData=0, SramEn=0, SramWe=0, SramBe=0, SramAddr=0, SramWData=0, ProtErr=0. nStall is forced to 1 while nReset=1.
- Reset mid-operation aborts the access: no further SRAM strobes are issued and any captured halfword is discarded.
- Reset has priority over every other event.
- FSM states: IDLE, RD_HI, RD_LO, RD_WAIT, WR_HI, WR_LO, DONE. All Sram* outputs are registered.
- nStall is combinational:
  - 0 when state ∈ {RD_HI, RD_LO, RD_WAIT, WR_HI, WR_LO};
  - 0 in IDLE when ReadEn|WriteEn;
  - 1 otherwise.
- IDLE transitions:
  - WriteEn → WR_HI.
  - ReadEn alone → RD_HI.
  - Address and WriteData are latched on this edge; later input changes are ignored.
- Read sequence (word at Address&~3; Address[1:0] is ignored):
  - RD_HI: SramEn=1, SramWe=0, SramAddr={A[15:2],0}.
  - RD_LO: SramAddr={A[15:2],1}; capture SramRData into ReadData[31:16].
  - RD_WAIT: SramEn=0; capture SramRData into ReadData[15:0].
  - DONE.
  - A read stalls 4 cycles (IDLE, RD_HI, RD_LO, RD_WAIT).
- Write sequence:
  - WR_HI: SramEn=1, SramWe=1, halfword 0, SramBe = mem-byte enables {b0,b1}.
  - WR_LO: halfword 1, SramBe = {b2,b3}.
  - DONE.
  - A write stalls 3 cycles. A halfword with SramBe=00 is still strobed (no skip), to keep latency fixed.
- Byte lanes (mem byte i = offset i of the aligned word; data byte j = WriteData[31-8j -: 8]; k = Address[1:0]):
  - Plain write: k must be 0; all four bytes written, mem byte i = data byte i.
  - WriteL: mem bytes k..3 get data bytes 0..3-k.
  - WriteR: mem bytes 0..k get data bytes 3-k..3.
- DONE: SramEn=0, nStall=1, core advances. Requests present in DONE are ignored (they belong to the finishing instruction). Next state is IDLE.
- ProtErr pulses one cycle after the IDLE sample for each of these cases:
  - ReadEn&WriteEn: treated as the write; the read is dropped.
  - WriteEn with neither qualifier and k≠0: the address is forced aligned, all four bytes are written.
  - WriteL&WriteR: treated as a plain aligned write.
  - WriteL|WriteR without WriteEn: ignored, no access.
- ReadData changes only in RD_LO/RD_WAIT; it holds across writes.

Test Plan:
- Reset, then idle 5 cycles → nStall=1, SramEn=0 throughout, ReadData=0.
- Preload SRAM[0x0010]=0xDEAD, [0x0011]=0xBEEF; ReadEn, Address=0x0022 → SramAddr 0x0010 then 0x0011; nStall low 4 cycles; ReadData=0xDEADBEEF in DONE.
- WriteEn, Address=0x0040, WriteData=0x12345678 → strobe 0x0020 Be=11 Data=0x1234, then 0x0021 Be=11 Data=0x5678; nStall low 3 cycles.
- WriteL, Address=0x0041, Data=0xAABBCCDD → hi Be=01 Data=0x00AA, lo Be=11 Data=0xBBCC. WriteR at the same address → hi Be=11 Data=0xCCDD, lo Be=00 Data=0x0000.
- ReadEn&WriteEn, Address=0x0040, Data=0x11223344 → ProtErr pulse, write performed, ReadData unchanged. WriteEn at Address=0x0042 → ProtErr, write at 0x0040.
- nReset asserted in RD_LO → next cycle state IDLE, SramEn=0, nStall=1, ReadData=0. A subsequent read of 0x0020 completes normally.
